// File: rtl/riscv_decode_stage.sv
// RV32 instruction-decode stage: register-address drive, immediate generation,
// writeback bypass into the operands, and an ID/EX register with valid/ready on both sides.
module riscv_decode_stage #(
  parameter int WORD_SIZE     = 32,
  parameter int REGFILE_COUNT = 32,
  localparam int RA_W         = $clog2(REGFILE_COUNT)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WORD_SIZE-1:0] pc_i,
  input  logic [31:0]          instr_i,
  input  logic                 flush_i,
  output logic [RA_W-1:0]      rs1_addr_o,
  output logic [RA_W-1:0]      rs2_addr_o,
  input  logic [WORD_SIZE-1:0] rs1_data_i,
  input  logic [WORD_SIZE-1:0] rs2_data_i,
  input  logic                 wb_en_i,
  input  logic [RA_W-1:0]      wb_addr_i,
  input  logic [WORD_SIZE-1:0] wb_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WORD_SIZE-1:0] pc_o,
  output logic [WORD_SIZE-1:0] imm_o,
  output logic [WORD_SIZE-1:0] rs1_data_o,
  output logic [WORD_SIZE-1:0] rs2_data_o,
  output logic [RA_W-1:0]      rd_o,
  output logic [2:0]           funct3_o,
  output logic [6:0]           funct7_o,
  output logic [6:0]           opcode_o,
  output logic                 illegal_o
);

  logic [6:0]           opcode;
  logic [RA_W-1:0]      rd_addr;
  logic [WORD_SIZE-1:0] imm_d;
  logic                 illegal_d;
  logic [WORD_SIZE-1:0] rs1_op;
  logic [WORD_SIZE-1:0] rs2_op;
  logic                 load;

  assign opcode     = instr_i[6:0];
  assign rs1_addr_o = instr_i[15 +: RA_W];
  assign rs2_addr_o = instr_i[20 +: RA_W];
  assign rd_addr    = instr_i[7 +: RA_W];

  always_comb begin
    imm_d     = '0;
    illegal_d = 1'b0;
    case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0001111:
        imm_d = WORD_SIZE'($signed(instr_i[31:20]));
      7'b0100011:
        imm_d = WORD_SIZE'($signed({instr_i[31:25], instr_i[11:7]}));
      7'b1100011:
        imm_d = WORD_SIZE'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                    instr_i[11:8], 1'b0}));
      7'b0110111, 7'b0010111:
        imm_d = WORD_SIZE'($signed({instr_i[31:12], 12'b0}));
      7'b1101111:
        imm_d = WORD_SIZE'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                    instr_i[30:21], 1'b0}));
      7'b0110011:
        imm_d = '0;
      default:
        illegal_d = 1'b1;
    endcase
    if (instr_i[1:0] != 2'b11) illegal_d = 1'b1;
    // RV32E only has x0..x15, so bit 4 of any register field is out of range
    if (REGFILE_COUNT == 16 && (instr_i[11] || instr_i[19] || instr_i[24])) illegal_d = 1'b1;
    if (illegal_d) imm_d = '0;
  end

  always_comb begin
    rs1_op = rs1_data_i;
    if (rs1_addr_o == '0) rs1_op = '0;
    else if (wb_en_i && wb_addr_i == rs1_addr_o) rs1_op = wb_data_i;
  end

  always_comb begin
    rs2_op = rs2_data_i;
    if (rs2_addr_o == '0) rs2_op = '0;
    else if (wb_en_i && wb_addr_i == rs2_addr_o) rs2_op = wb_data_i;
  end

  assign in_ready_o = !out_valid_o || out_ready_i || flush_i;
  assign load       = in_valid_i && in_ready_o && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (load) begin
      out_valid_o <= 1'b1;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  // Payload is only written on a load; flush leaves it untouched
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_o       <= '0;
      imm_o      <= '0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      rd_o       <= '0;
      funct3_o   <= '0;
      funct7_o   <= '0;
      opcode_o   <= '0;
      illegal_o  <= 1'b0;
    end else if (load) begin
      pc_o       <= pc_i;
      imm_o      <= imm_d;
      rs1_data_o <= rs1_op;
      rs2_data_o <= rs2_op;
      rd_o       <= rd_addr;
      funct3_o   <= instr_i[14:12];
      funct7_o   <= instr_i[31:25];
      opcode_o   <= opcode;
      illegal_o  <= illegal_d;
    end
  end

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Bench for riscv_decode_stage: directed vectors, an arithmetic decode model checked
// every cycle, and literal expectations for the documented example instructions.
module tb_riscv_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, wb_en, out_ready;
  logic [31:0] pc, instr, rs1d, rs2d, wb_data;
  logic [4:0]  wb_addr;

  logic        in_ready, out_valid, illegal;
  logic [4:0]  rs1_addr, rs2_addr, rd;
  logic [31:0] pc_o, imm, r1_o, r2_o;
  logic [2:0]  f3;
  logic [6:0]  f7, op;

  logic        e_in_ready, e_out_valid, e_illegal;
  logic [3:0]  e_rs1_addr, e_rs2_addr, e_rd;
  logic [31:0] e_pc, e_imm, e_r1, e_r2;
  logic [2:0]  e_f3;
  logic [6:0]  e_f7, e_op;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  riscv_decode_stage #(.WORD_SIZE(32), .REGFILE_COUNT(32)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .pc_i(pc), .instr_i(instr), .flush_i(flush),
    .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
    .rs1_data_i(rs1d), .rs2_data_i(rs2d),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .pc_o(pc_o), .imm_o(imm), .rs1_data_o(r1_o), .rs2_data_o(r2_o),
    .rd_o(rd), .funct3_o(f3), .funct7_o(f7), .opcode_o(op), .illegal_o(illegal)
  );

  riscv_decode_stage #(.WORD_SIZE(32), .REGFILE_COUNT(16)) dut_e (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(e_in_ready),
    .pc_i(pc), .instr_i(instr), .flush_i(flush),
    .rs1_addr_o(e_rs1_addr), .rs2_addr_o(e_rs2_addr),
    .rs1_data_i(rs1d), .rs2_data_i(rs2d),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr[3:0]), .wb_data_i(wb_data),
    .out_valid_o(e_out_valid), .out_ready_i(out_ready),
    .pc_o(e_pc), .imm_o(e_imm), .rs1_data_o(e_r1), .rs2_data_o(e_r2),
    .rd_o(e_rd), .funct3_o(e_f3), .funct7_o(e_f7), .opcode_o(e_op), .illegal_o(e_illegal)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode written from the format tables as plain arithmetic
  function automatic logic m_ill(input logic [31:0] i);
    logic [6:0] o;
    o = i[6:0];
    if (i[1:0] != 2'b11) return 1'b1;
    return !(o == 7'h03 || o == 7'h13 || o == 7'h67 || o == 7'h73 || o == 7'h0F ||
             o == 7'h23 || o == 7'h63 || o == 7'h37 || o == 7'h17 || o == 7'h6F ||
             o == 7'h33);
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] i);
    int v;
    v = 0;
    if (m_ill(i)) return 32'h0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: v = $signed(i) >>> 20;
      7'h23: v = (($signed(i) >>> 25) * 32) + int'(i[11:7]);
      7'h63: begin
        if (i[31]) v -= 4096;
        v += int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      end
      7'h37, 7'h17: v = int'(i & 32'hFFFF_F000);
      7'h6F: begin
        if (i[31]) v -= (1 << 20);
        v += int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
      end
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_opnd(input logic [4:0] a, input logic [31:0] d);
    if (a == 0) return 32'h0;
    if (wb_en && wb_addr == a) return wb_data;
    return d;
  endfunction

  logic        m_valid, m_ill_q;
  logic [31:0] m_pc, m_imm_q, m_r1, m_r2, m_instr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0; m_pc <= 0; m_imm_q <= 0; m_r1 <= 0; m_r2 <= 0;
      m_instr <= 0; m_ill_q <= 1'b0;
    end else begin
      if (in_valid && !flush && (!m_valid || out_ready)) begin
        m_valid <= 1'b1;
        m_pc    <= pc;
        m_instr <= instr;
        m_imm_q <= m_imm(instr);
        m_ill_q <= m_ill(instr);
        m_r1    <= m_opnd(instr[19:15], rs1d);
        m_r2    <= m_opnd(instr[24:20], rs2d);
      end else if (flush || out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", out_valid, m_valid);
      chk("in_ready", in_ready, !m_valid || out_ready || flush);
      chk("rs1_addr", rs1_addr, instr[19:15]);
      chk("rs2_addr", rs2_addr, instr[24:20]);
      chk("pc", pc_o, m_pc);
      chk("imm", imm, m_imm_q);
      chk("rs1_data", r1_o, m_r1);
      chk("rs2_data", r2_o, m_r2);
      chk("rd", rd, m_instr[11:7]);
      chk("funct3", f3, m_instr[14:12]);
      chk("funct7", f7, m_instr[31:25]);
      chk("opcode", op, m_instr[6:0]);
      chk("illegal", illegal, m_ill_q);
    end
  end

  task automatic present(input logic [31:0] p, input logic [31:0] i,
                         input logic [31:0] d1, input logic [31:0] d2);
    in_valid = 1'b1; pc = p; instr = i; rs1d = d1; rs2d = d2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] stream_i [4];
  initial begin
    stream_i[0] = 32'h0020_81B3;  // add x3,x1,x2
    stream_i[1] = 32'hFFF1_0113;  // addi x2,x2,-1
    stream_i[2] = 32'h0041_2423;  // sw x4,8(x2)
    stream_i[3] = 32'h0000_0517;  // auipc x10,0
  end

  initial begin
    rst = 1'b1; in_valid = 0; flush = 0; wb_en = 0; out_ready = 1'b1;
    pc = 0; instr = 0; rs1d = 0; rs2d = 0; wb_addr = 0; wb_data = 0;
    #12;
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset pc", pc_o, 0);
    chk("reset illegal", illegal, 0);
    tick();
    rst = 1'b0;

    present(32'h100, 32'h0050_0093, 32'h55, 32'h66);  // addi x1,x0,5
    tick();
    chk("addi valid", out_valid, 1);
    chk("addi imm", imm, 5);
    chk("addi rd", rd, 1);
    chk("addi rs1 x0", r1_o, 0);
    chk("addi pc", pc_o, 32'h100);

    present(32'h104, 32'hFE11_2E23, 0, 0); tick(); chk("sw imm", imm, 32'hFFFF_FFFC);
    present(32'h108, 32'hFE00_0EE3, 0, 0); tick(); chk("beq imm", imm, 32'hFFFF_FFFC);
    present(32'h10C, 32'h1234_50B7, 0, 0); tick(); chk("lui imm", imm, 32'h1234_5000);
    present(32'h110, 32'hFFDF_F0EF, 0, 0); tick(); chk("jal imm", imm, 32'hFFFF_FFFC);

    present(32'h114, 32'h0020_81B3, 7, 32'h22);  // add x3,x1,x2
    wb_en = 1; wb_addr = 1; wb_data = 9;
    tick();
    chk("bypass rs1", r1_o, 9);
    chk("bypass rs2 no hit", r2_o, 32'h22);
    present(32'h118, 32'h0020_01B3, 7, 32'h22);  // add x3,x0,x2
    wb_addr = 0;
    tick();
    chk("x0 ignores wb", r1_o, 0);
    wb_en = 0;

    present(32'h200, 32'h0070_0293, 0, 0);  // addi x5,x0,7
    tick();
    out_ready = 0;
    present(32'h204, 32'h0080_0313, 0, 0);  // addi x6,x0,8
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall in_ready", in_ready, 0);
      chk("stall pc held", pc_o, 32'h200);
      chk("stall imm held", imm, 7);
    end
    out_ready = 1; #1;
    chk("release in_ready", in_ready, 1);
    tick();
    chk("drain+load valid", out_valid, 1);
    chk("drain+load pc", pc_o, 32'h204);
    out_ready = 0;
    present(32'h208, 32'h0090_0393, 0, 0);
    tick();
    flush = 1; #1;
    chk("flush in_ready", in_ready, 1);
    tick();
    chk("flush valid", out_valid, 0);
    chk("flush keeps pc", pc_o, 32'h204);
    flush = 0; in_valid = 0;
    tick();
    chk("flush dropped input", out_valid, 0);

    out_ready = 1;
    present(32'h300, 32'h0000_007F, 0, 0); tick();
    chk("bad opcode illegal", illegal, 1); chk("bad opcode imm", imm, 0);
    present(32'h304, 32'h0050_0090, 0, 0); tick();
    chk("low bits illegal", illegal, 1); chk("low bits imm", imm, 0);
    present(32'h308, 32'h0050_0893, 0, 0); tick();  // addi x17,x0,5
    chk("rv32i x17 legal", illegal, 0);
    chk("rv32e x17 illegal", e_illegal, 1);
    chk("rv32e x17 imm", e_imm, 0);
    present(32'h30C, 32'h0050_0093, 0, 0); tick();
    chk("rv32e x1 legal", e_illegal, 0);

    for (int k = 0; k < 4; k++) begin
      wb_en = k[0]; wb_addr = 5'd2; wb_data = 32'hA000 + k;
      present(32'h400 + 4 * k, stream_i[k], 32'h10 + k, 32'h20 + k);
      tick();
    end
    wb_en = 0;

    present(32'h500, 32'h0070_0293, 0, 0);
    out_ready = 0;
    tick();
    rst = 1; #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst pc", pc_o, 0);
    chk("rst imm", imm, 0);
    chk("rst in_ready", in_ready, 1);
    in_valid = 0; out_ready = 1;
    tick();
    rst = 0;
    tick();
    chk("post-rst valid", out_valid, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
